// File: rtl/bcd_counter_2d.sv
// Two-digit BCD up/down counter (00-99) with prescaler and run/stop FSM.
// Feeds the BCD-to-14-segment decoders; digits are always 0..9.
module bcd_counter_2d #(
   parameter int PRESCALE = 50_000_000,
   parameter int PS_W     = 26
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start_stop,
   input  logic       clr,
   input  logic       load,
   input  logic       up,
   input  logic [3:0] load_tens,
   input  logic [3:0] load_ones,
   output logic [3:0] tens,
   output logic [3:0] ones,
   output logic       running,
   output logic       tick,
   output logic       wrap
);

   typedef enum logic {
      STOP = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t state, state_nxt;

   logic [PS_W-1:0] ps;
   logic            tc;
   logic [3:0]      st_tens, st_ones;
   logic            st_wrap;

   function automatic logic [3:0] sat9(input logic [3:0] d);
      return (d > 4'd9) ? 4'd9 : d;
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= STOP;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (start_stop)
         state_nxt = (state == RUN) ? STOP : RUN;
   end

   assign running = (state == RUN);

   // Terminal count uses the pre-edge state, so a RUN->STOP edge still steps.
   assign tc = (state == RUN) && (ps == PS_W'(PRESCALE - 1));

   always_comb begin
      st_tens = tens;
      st_ones = ones;
      st_wrap = 1'b0;
      if (up) begin
         if (ones != 4'd9) begin
            st_ones = ones + 4'd1;
         end else begin
            st_ones = 4'd0;
            if (tens != 4'd9) begin
               st_tens = tens + 4'd1;
            end else begin
               st_tens = 4'd0;
               st_wrap = 1'b1;
            end
         end
      end else begin
         if (ones != 4'd0) begin
            st_ones = ones - 4'd1;
         end else begin
            st_ones = 4'd9;
            if (tens != 4'd0) begin
               st_tens = tens - 4'd1;
            end else begin
               st_tens = 4'd9;
               st_wrap = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ps   <= '0;
         tens <= 4'd0;
         ones <= 4'd0;
         tick <= 1'b0;
         wrap <= 1'b0;
      end else begin
         tick <= 1'b0;
         wrap <= 1'b0;
         if (clr) begin
            ps   <= '0;
            tens <= 4'd0;
            ones <= 4'd0;
         end else if (load) begin
            ps   <= '0;
            tens <= sat9(load_tens);
            ones <= sat9(load_ones);
         end else if (state == RUN) begin
            if (tc) begin
               ps   <= '0;
               tens <= st_tens;
               ones <= st_ones;
               tick <= 1'b1;
               wrap <= st_wrap;
            end else begin
               ps <= ps + PS_W'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_bcd_counter_2d.sv
// Bench for bcd_counter_2d: directed plan plus random traffic
// against an integer 0..99 reference model.
module tb_bcd_counter_2d;

   localparam int PRESCALE = 4;
   localparam int PS_W     = 3;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start_stop = 1'b0;
   logic       clr = 1'b0;
   logic       load = 1'b0;
   logic       up = 1'b1;
   logic [3:0] load_tens = 4'd0;
   logic [3:0] load_ones = 4'd0;
   logic [3:0] tens, ones;
   logic       running, tick, wrap;

   bcd_counter_2d #(.PRESCALE(PRESCALE), .PS_W(PS_W)) dut (
      .clk(clk),
      .rst(rst),
      .start_stop(start_stop),
      .clr(clr),
      .load(load),
      .up(up),
      .load_tens(load_tens),
      .load_ones(load_ones),
      .tens(tens),
      .ones(ones),
      .running(running),
      .tick(tick),
      .wrap(wrap)
   );

   always #5 clk = ~clk;

   int total = 0;
   int passed = 0;

   int m_val = 0;
   int m_ps = 0;
   bit m_run = 0;
   bit m_tick = 0;
   bit m_wrap = 0;

   task automatic chk(input string name, input int obs, input int exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0d expected=%0d", name, obs, exp);
   endtask

   function automatic int sat(input int d);
      return (d > 9) ? 9 : d;
   endfunction

   task automatic model_edge();
      m_tick = 0;
      m_wrap = 0;
      if (rst) begin
         m_val = 0; m_ps = 0; m_run = 0;
      end else begin
         if (clr) begin
            m_val = 0; m_ps = 0;
         end else if (load) begin
            m_val = sat(int'(load_tens)) * 10 + sat(int'(load_ones));
            m_ps = 0;
         end else if (m_run) begin
            if (m_ps == PRESCALE - 1) begin
               m_ps = 0;
               m_tick = 1;
               if (up) begin
                  m_wrap = (m_val == 99);
                  m_val = (m_val + 1) % 100;
               end else begin
                  m_wrap = (m_val == 0);
                  m_val = (m_val + 99) % 100;
               end
            end else begin
               m_ps++;
            end
         end
         if (start_stop) m_run = !m_run;
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      model_edge();
      #1;
      chk("tens", int'(tens), m_val / 10);
      chk("ones", int'(ones), m_val % 10);
      chk("running", int'(running), int'(m_run));
      chk("tick", int'(tick), int'(m_tick));
      chk("wrap", int'(wrap), int'(m_wrap));
   endtask

   task automatic wait_tick(input string name, input int exp_n);
      int n = 0;
      do begin
         cycle();
         n++;
      end while (!tick && n < 40);
      chk(name, n, exp_n);
   endtask

   task automatic pulse_ss();
      start_stop = 1'b1;
      cycle();
      start_stop = 1'b0;
   endtask

   initial begin
      int frozen;
      int n;
      repeat (2) cycle();
      rst = 1'b0;
      cycle();

      // 1: start and count up
      up = 1'b1;
      pulse_ss();
      chk("t1_running", int'(running), 1);
      wait_tick("t1_lat", 4);
      chk("t1_ones1", int'(ones), 1);
      wait_tick("t1_per", 4);
      chk("t1_ones2", int'(ones), 2);
      cycle();
      chk("t1_tick_1cyc", int'(tick), 0);

      // 2: up wrap 98 -> 99 -> 00 -> 01
      load_tens = 4'd9; load_ones = 4'd8; load = 1'b1;
      cycle();
      load = 1'b0;
      wait_tick("t2_a", 4);
      chk("t2_99", int'(tens) * 10 + int'(ones), 99);
      chk("t2_nowrap99", int'(wrap), 0);
      wait_tick("t2_b", 4);
      chk("t2_00", int'(tens) * 10 + int'(ones), 0);
      chk("t2_wrap", int'(wrap), 1);
      wait_tick("t2_c", 4);
      chk("t2_01", int'(ones), 1);
      chk("t2_wrap01", int'(wrap), 0);

      // 3: down from 10 through 00 to 99, then saturated load
      up = 1'b0;
      load_tens = 4'd1; load_ones = 4'd0; load = 1'b1;
      cycle();
      load = 1'b0;
      repeat (11) wait_tick("t3_step", 4);
      chk("t3_99", int'(tens) * 10 + int'(ones), 99);
      chk("t3_wrap", int'(wrap), 1);
      load_tens = 4'd12; load_ones = 4'd15; load = 1'b1;
      cycle();
      load = 1'b0;
      chk("t3_sat_t", int'(tens), 9);
      chk("t3_sat_o", int'(ones), 9);

      // 4: clr+load at terminal count discards the step
      up = 1'b1;
      n = 0;
      while (m_ps != PRESCALE - 1 && n < 10) begin
         cycle();
         n++;
      end
      chk("t4_reach_tc", m_ps, PRESCALE - 1);
      clr = 1'b1; load = 1'b1; load_tens = 4'd5; load_ones = 4'd5;
      cycle();
      clr = 1'b0; load = 1'b0;
      chk("t4_notick", int'(tick), 0);
      chk("t4_zero", int'(tens) * 10 + int'(ones), 0);
      wait_tick("t4_lat", 4);

      // 5: stop 2 cycles into a period, prescaler held
      cycle();
      pulse_ss();
      chk("t5_stopped", int'(running), 0);
      frozen = m_val;
      repeat (20) cycle();
      chk("t5_frozen", int'(tens) * 10 + int'(ones), frozen);
      pulse_ss();
      wait_tick("t5_lat", 2);

      // 6: async reset mid-period at 57
      load_tens = 4'd5; load_ones = 4'd7; load = 1'b1;
      cycle();
      load = 1'b0;
      cycle();
      chk("t6_57", int'(tens) * 10 + int'(ones), 57);
      #3;
      rst = 1'b1;
      m_val = 0; m_ps = 0; m_run = 0; m_tick = 0; m_wrap = 0;
      #1;
      chk("t6_tens", int'(tens), 0);
      chk("t6_ones", int'(ones), 0);
      chk("t6_run", int'(running), 0);
      chk("t6_tick", int'(tick), 0);
      repeat (2) cycle();
      rst = 1'b0;
      n = 0;
      repeat (12) begin
         cycle();
         n += int'(tick);
      end
      chk("t6_idle_ticks", n, 0);

      // random traffic
      pulse_ss();
      repeat (800) begin
         start_stop = ($urandom_range(0, 30) == 0);
         clr        = ($urandom_range(0, 60) == 0);
         load       = ($urandom_range(0, 40) == 0);
         load_tens  = 4'($urandom_range(0, 15));
         load_ones  = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 20) == 0) up = ~up;
         cycle();
      end
      start_stop = 1'b0; clr = 1'b0; load = 1'b0;
      cycle();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
